// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq_ctrl command sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_ADD = 3'd2,
        OP_SUB = 3'd3,
        OP_MUL = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam int unsigned MUL_ITERS = 8;

    // Map a legal single-pass command opcode onto the ALU Operation code.
    function automatic logic [3:0] alu_opcode(input logic [2:0] op);
        case (op)
            OP_AND:  alu_opcode = ALU_AND;
            OP_OR:   alu_opcode = ALU_OR;
            OP_ADD:  alu_opcode = ALU_ADD;
            OP_SUB:  alu_opcode = ALU_SUB;
            default: alu_opcode = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/eight_bit_ALU.sv
// Combinational 8-bit ALU: AND, OR, ADD, SUB (modulo 2^8) with zero flag.
module eight_bit_ALU (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] Operation,
    output logic [7:0] Result,
    output logic       isZero
);

    // Select the operation result; unknown codes yield zero.
    always_comb begin
        Result = '0;
        case (Operation)
            4'b0000: Result = a & b;
            4'b0001: Result = a | b;
            4'b0010: Result = a + b;
            4'b0110: Result = a - b;
            default: Result = '0;
        endcase
        isZero = (Result == '0);
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer around one eight_bit_ALU: single-pass AND/OR/ADD/SUB and an
// 8-cycle shift-add MUL reusing the ALU adder. Optional handshake counter
// perf_ops is enabled by defining ALU_SEQ_PERF_EN.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     in_op,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_result,
    output logic           out_zero,
`ifdef ALU_SEQ_PERF_EN
    output logic [15:0]    perf_ops,
`endif
    output logic           out_err
);

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       lo_q, lo_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]     res_q, res_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;

    logic [W-1:0]       alu_a, alu_b, alu_res;
    logic [3:0]         alu_op;
    logic               alu_zero;
    logic               mul_carry;
    logic [2*W:0]       mul_step;

    eight_bit_ALU u_alu (
        .a         (alu_a),
        .b         (alu_b),
        .Operation (alu_op),
        .Result    (alu_res),
        .isZero    (alu_zero)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    // Next-state, ALU drive and result capture.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        zero_d    = zero_q;
        err_d     = err_q;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = ALU_AND;
        mul_carry = 1'b0;
        mul_step  = '0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d  = in_op;
                    a_d   = in_a;
                    lo_d  = in_b;
                    err_d = 1'b0;
                    if (in_op == OP_MUL) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = MUL;
                    end else if (in_op > OP_MUL) begin
                        err_d   = 1'b1;
                        res_d   = '0;
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                alu_a   = a_q;
                alu_b   = lo_q;
                alu_op  = alu_opcode(op_q);
                res_d   = {{W{1'b0}}, alu_res};
                zero_d  = alu_zero;
                state_d = DONE;
            end
            MUL: begin
                // Adder carry-out recovered by compare; the sum and the
                // shifted multiplier form one 17-bit right-shifted word.
                alu_a     = acc_q;
                alu_b     = lo_q[0] ? a_q : '0;
                alu_op    = ALU_ADD;
                mul_carry = (alu_res < acc_q);
                mul_step  = {mul_carry, alu_res, lo_q[W-1:1]};
                acc_d     = mul_step[2*W-1:W];
                lo_d      = mul_step[W-1:0];
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MUL_ITERS - 1)) begin
                    res_d   = mul_step[2*W-1:0];
                    zero_d  = (mul_step[2*W-1:0] == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = res_q;
    assign out_zero   = zero_q;
    assign out_err    = err_q;

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] perf_q;

    // Saturating count of completed result handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (out_valid && out_ready && (perf_q != '1)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_ops = perf_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl (define ALU_SEQ_PERF_EN to
// also check perf_ops).
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_zero;
    logic        out_err;
`ifdef ALU_SEQ_PERF_EN
    logic [15:0] perf_ops;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    alu_seq_ctrl #(.W(8), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
`ifdef ALU_SEQ_PERF_EN
        .perf_ops   (perf_ops),
`endif
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command, wait (bounded) for in_ready, and take the accept edge.
    task automatic issue(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned waited;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        check({tag, "_ready_wait"}, {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_a     = 8'hAA;
        in_b     = 8'h55;
    endtask

    // Issue a command, check the exact out_valid latency and result, consume it.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input int unsigned lat,
                           input logic [15:0] exp_res, input logic exp_zero, input logic exp_err);
        issue(tag, op, a, b);
        for (int unsigned i = 0; i < lat; i++) begin
            check({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
            step();
        end
        check({tag, "_valid"},  {31'd0, out_valid}, 32'd1);
        check({tag, "_result"}, {16'd0, out_result}, {16'd0, exp_res});
        check({tag, "_zero"},   {31'd0, out_zero}, {31'd0, exp_zero});
        check({tag, "_err"},    {31'd0, out_err},  {31'd0, exp_err});
        step();
        check({tag, "_idle"},   {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result",    {16'd0, out_result}, 32'd0);
        check("rst_zero",      {31'd0, out_zero},  32'd0);
        check("rst_err",       {31'd0, out_err},   32'd0);
        rst_n = 1'b1;
        step();

        run_cmd("add_7f_01", 3'd2, 8'h7F, 8'h01, 1, 16'h0080, 1'b0, 1'b0);
        run_cmd("sub_eq",    3'd3, 8'h05, 8'h05, 1, 16'h0000, 1'b1, 1'b0);
        run_cmd("sub_wrap",  3'd3, 8'h00, 8'h01, 1, 16'h00FF, 1'b0, 1'b0);
        run_cmd("add_wrap",  3'd2, 8'hFF, 8'h01, 1, 16'h0000, 1'b1, 1'b0);
        run_cmd("mul_ff_ff", 3'd4, 8'hFF, 8'hFF, 8, 16'hFE01, 1'b0, 1'b0);
        run_cmd("mul_0d_0b", 3'd4, 8'h0D, 8'h0B, 8, 16'h008F, 1'b0, 1'b0);
        run_cmd("mul_00_5a", 3'd4, 8'h00, 8'h5A, 8, 16'h0000, 1'b1, 1'b0);

        // Back-pressure on an AND result.
        out_ready = 1'b0;
        issue("and_bp", 3'd0, 8'hF0, 8'h3C);
        step();
        for (int unsigned i = 0; i < 5; i++) begin
            check("bp_valid",    {31'd0, out_valid}, 32'd1);
            check("bp_result",   {16'd0, out_result}, 32'h0030);
            check("bp_in_ready", {31'd0, in_ready},  32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_idle",      {31'd0, in_ready},  32'd1);
        check("bp_valid_off", {31'd0, out_valid}, 32'd0);

        run_cmd("illegal_6", 3'd6, 8'h12, 8'h34, 0, 16'h0000, 1'b1, 1'b1);
        run_cmd("or_after",  3'd1, 8'h0F, 8'hF0, 1, 16'h00FF, 1'b0, 1'b0);

        // Reset during the 4th MUL iteration discards the command.
        issue("mul_rst", 3'd4, 8'h0D, 8'h0B);
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        check("midrst_valid",  {31'd0, out_valid}, 32'd0);
        check("midrst_ready",  {31'd0, in_ready},  32'd1);
        check("midrst_result", {16'd0, out_result}, 32'd0);
        rst_n = 1'b1;
        run_cmd("add_2_3", 3'd2, 8'h02, 8'h03, 1, 16'h0005, 1'b0, 1'b0);
`ifdef ALU_SEQ_PERF_EN
        check("perf_ops", {16'd0, perf_ops}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
